// File: rtl/pattern_gen.sv
// pattern_gen: steps a WIDTH-bit stimulus vector through binary, Gray, walking-one or LFSR
// sequences, holding each vector HOLD cycles, one pass per start command.
module pattern_gen #(
    parameter int WIDTH = 5,
    parameter int HOLD = 2,
    parameter logic [WIDTH-1:0] TAPS = 5'h14
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_seed,
    output logic [WIDTH-1:0] o_vec,
    output logic [WIDTH-1:0] o_idx,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_done
);
    localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [WIDTH-1:0] ONES = '1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [1:0] mode;
    logic [HW-1:0] hold;
    logic [WIDTH-1:0] nidx, nvec, last, first;
    // o_idx doubles as the binary counter for modes 00/01; the LFSR state lives in o_vec
    always_comb begin
        nidx = o_idx + 1'b1;
        last = mode == 2'b10 ? WIDTH'(WIDTH - 1) : mode == 2'b11 ? ONES - 1'b1 : ONES;
        nvec = mode == 2'b00 ? nidx :
               mode == 2'b01 ? nidx ^ (nidx >> 1) :
               mode == 2'b10 ? {o_vec[WIDTH-2:0], o_vec[WIDTH-1]} :
               (o_vec >> 1) ^ (o_vec[0] ? TAPS : '0);
        first = i_mode == 2'b10 ? WIDTH'(1) :
                i_mode == 2'b11 ? (i_seed == '0 ? WIDTH'(1) : i_seed) : '0;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            mode    <= '0;
            hold    <= '0;
            o_vec   <= '0;
            o_idx   <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_start && !i_stop) begin
                    state   <= RUN;
                    mode    <= i_mode;
                    hold    <= '0;
                    o_vec   <= first;
                    o_idx   <= '0;
                    o_valid <= 1'b1;
                    o_busy  <= 1'b1;
                end
                RUN: if (i_stop) begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end else if (hold == HOLD_LAST) begin
                    hold <= '0;
                    if (o_idx == last) begin
                        state   <= DONE;
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                    end else begin
                        o_idx <= nidx;
                        o_vec <= nvec;
                    end
                end else begin
                    hold <= hold + 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: directed scoreboard bench for pattern_gen at WIDTH=5, HOLD=2.
module tb_pattern_gen;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [4:0] seed = 5'h0;
    logic [4:0] vec, idx;
    logic valid, busy, done;
    int total = 0, bad = 0;
    logic [4:0] q_vec[$], q_idx[$], seen[$];

    pattern_gen dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .i_mode(mode), .i_seed(seed), .o_vec(vec), .o_idx(idx),
        .o_valid(valid), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model_vec(input logic [1:0] m, input int i, input logic [4:0] sd);
        logic [4:0] s, b, one;
        b = 5'(i);
        one = 5'd1;
        case (m)
            2'b00: return b;
            2'b01: return b ^ (b >> 1);
            2'b10: return one << i;
            default: begin
                s = (sd == 5'd0) ? 5'd1 : sd;
                for (int k = 0; k < i; k++) s = (s >> 1) ^ (s[0] ? 5'h14 : 5'h00);
                return s;
            end
        endcase
    endfunction

    function automatic int seq_len(input logic [1:0] m);
        return m < 2 ? 32 : (m == 2 ? 5 : 31);
    endfunction

    task automatic run_pass(input logic [1:0] m, input logic [4:0] sd, input bit poke);
        int len, n;
        logic [4:0] ev, ei, lv, li;
        len = seq_len(m);
        for (int i = 0; i < len; i++)
            for (int h = 0; h < 2; h++) begin
                q_vec.push_back(model_vec(m, i, sd));
                q_idx.push_back(5'(i));
            end
        lv = model_vec(m, len - 1, sd);
        li = 5'(len - 1);
        seen.delete();
        mode = m; seed = sd; start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_first", busy, 1);
        n = 0;
        while (valid && n < 200) begin
            if (poke && n == 5) begin start = 1'b1; mode = ~m; seed = ~sd; end
            if (poke && n == 7) start = 1'b0;
            if (q_vec.size() == 0) begin
                chk("queue_underflow", 1, 0);
                break;
            end
            ev = q_vec.pop_front();
            ei = q_idx.pop_front();
            chk("vec", vec, ev);
            chk("idx", idx, ei);
            if (n % 2 == 0) seen.push_back(vec);
            n++;
            step();
        end
        mode = m; seed = sd;
        chk("valid_cycles", n, len * 2);
        chk("queue_empty", q_vec.size(), 0);
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 0);
        chk("vec_hold_done", vec, lv);
        chk("idx_hold_done", idx, li);
        q_vec.delete(); q_idx.delete();
        step();
        chk("done_clear", done, 0);
        chk("vec_hold_idle", vec, lv);
        chk("idx_hold_idle", idx, li);
    endtask

    initial begin
        int dup, badstep;
        logic [31:0] hit;
        step(); step();
        chk("rst_vec", vec, 0);
        chk("rst_idx", idx, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        step();

        run_pass(2'b00, 5'h0, 1'b0);

        run_pass(2'b01, 5'h0, 1'b0);
        badstep = 0;
        for (int i = 1; i < seen.size(); i++)
            if ($countones(seen[i] ^ seen[i-1]) != 1) badstep++;
        chk("gray_onebit", badstep, 0);
        chk("gray_last", seen[seen.size()-1], 5'h10);

        run_pass(2'b10, 5'h0, 1'b0);
        chk("walk_4", seen[4], 5'b10000);

        run_pass(2'b11, 5'h0, 1'b0);
        hit = '0; dup = 0;
        foreach (seen[i]) begin
            if (hit[seen[i]]) dup++;
            hit[seen[i]] = 1'b1;
        end
        chk("lfsr_first_seed0", seen[0], 1);
        chk("lfsr_count", seen.size(), 31);
        chk("lfsr_dups", dup, 0);
        chk("lfsr_nonzero", hit[0], 0);

        run_pass(2'b11, 5'h13, 1'b0);
        chk("lfsr_seed13_0", seen[0], 5'h13);
        chk("lfsr_seed13_1", seen[1], 5'h1d);

        // abort on the 7th valid cycle of a binary pass
        mode = 2'b00; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 7; k++) step();
        chk("abort_pre_valid", valid, 1);
        chk("abort_pre_vec", vec, 3);
        stop = 1'b1;
        step();
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_vec_hold", vec, 3);
        stop = 1'b0;
        dup = 0;
        for (int k = 0; k < 5; k++) begin
            if (done !== 1'b0) dup++;
            step();
        end
        chk("abort_no_done", dup, 0);
        start = 1'b1; stop = 1'b1;
        step();
        chk("collide_valid", valid, 0);
        chk("collide_busy", busy, 0);
        start = 1'b0; stop = 1'b0;
        step();
        chk("collide_idle", busy, 0);

        run_pass(2'b00, 5'h0, 1'b1);

        // asynchronous reset mid-pass
        mode = 2'b00; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 100 && !(valid && idx == 5'd9); k++) step();
        chk("reach_idx9", idx, 9);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vec", vec, 0);
        chk("arst_idx", idx, 0);
        chk("arst_valid", valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        step();
        rst_n = 1'b1;
        step();
        run_pass(2'b00, 5'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
